// File: rtl/control_unit_if.sv
// Control bundle between the Maquina Rudimentaria sequencer and its datapath.
// The master side decodes IR and flags and drives every load/select strobe.
interface control_unit_if;
    logic [15:0] ir;
    logic        flag_z;
    logic        flag_n;
    logic        ld_ir;
    logic        ld_pc;
    logic        reset_pc_sel;
    logic        mux_1_pc;
    logic        ld_rdir;
    logic        mem_w;
    logic        ld_reg;
    logic        reg_src;
    logic        rb_sel;
    logic        ld_flags;
    logic [3:0]  state;

    modport master (
        input  ir, flag_z, flag_n,
        output ld_ir, ld_pc, reset_pc_sel, mux_1_pc, ld_rdir, mem_w,
               ld_reg, reg_src, rb_sel, ld_flags, state
    );

    modport slave (
        output ir, flag_z, flag_n,
        input  ld_ir, ld_pc, reset_pc_sel, mux_1_pc, ld_rdir, mem_w,
               ld_reg, reg_src, rb_sel, ld_flags, state
    );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the Maquina Rudimentaria: fetch, decode, load/store/ALU
// execution and branch with target prefetch. Outputs depend on state only.
//
// state | meaning
// RST   | hold PC mux at 0 and load it
// F0    | present PC to memory
// F1    | IR <= mem[PC], PC <= PC+1
// DEC   | RDIR <= Ri + IR[7:0], dispatch on opcode
// LD0   | present RDIR to memory
// LD1   | Rd <= mem[RDIR], update flags
// ST    | mem[RDIR] <= Rs, single write cycle
// ALU   | Rd <= ALU result, update flags
// BR0   | present branch target to memory
// BR1   | IR <= mem[RDIR], PC <= RDIR+1, skip normal fetch
module control_unit (
    input  logic                  clk,
    input  logic                  rst,
    control_unit_if.master        cu_bus
);

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F0  = 4'd1,
        S_F1  = 4'd2,
        S_DEC = 4'd3,
        S_LD0 = 4'd4,
        S_LD1 = 4'd5,
        S_ST  = 4'd6,
        S_ALU = 4'd7,
        S_BR0 = 4'd8,
        S_BR1 = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RST;
        else     r_state <= w_next;
    end

    always_comb begin
        w_taken = 1'b0;
        case (cu_bus.ir[13:11])
            3'b000: w_taken = 1'b1;
            3'b001: w_taken = cu_bus.flag_z;
            3'b010: w_taken = cu_bus.flag_n;
            3'b011: w_taken = cu_bus.flag_n | cu_bus.flag_z;
            3'b100: w_taken = 1'b0;
            3'b101: w_taken = ~cu_bus.flag_z;
            3'b110: w_taken = ~cu_bus.flag_n;
            3'b111: w_taken = ~cu_bus.flag_n & ~cu_bus.flag_z;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST: w_next = S_F0;
            S_F0:  w_next = S_F1;
            S_F1:  w_next = S_DEC;
            S_DEC: begin
                case (cu_bus.ir[15:14])
                    2'b00:   w_next = S_LD0;
                    2'b01:   w_next = S_ST;
                    2'b10:   w_next = w_taken ? S_BR0 : S_F0;
                    default: w_next = S_ALU;
                endcase
            end
            S_LD0: w_next = S_LD1;
            S_LD1: w_next = S_F0;
            S_ST:  w_next = S_F0;
            S_ALU: w_next = S_F0;
            S_BR0: w_next = S_BR1;
            S_BR1: w_next = S_DEC;
            default: w_next = S_RST;
        endcase
    end

    // Moore outputs; illegal codes fall through to all-zero
    always_comb begin
        cu_bus.ld_ir        = 1'b0;
        cu_bus.ld_pc        = 1'b0;
        cu_bus.reset_pc_sel = 1'b0;
        cu_bus.mux_1_pc     = 1'b0;
        cu_bus.ld_rdir      = 1'b0;
        cu_bus.mem_w        = 1'b0;
        cu_bus.ld_reg       = 1'b0;
        cu_bus.reg_src      = 1'b0;
        cu_bus.rb_sel       = 1'b0;
        cu_bus.ld_flags     = 1'b0;
        case (r_state)
            S_RST: begin
                cu_bus.reset_pc_sel = 1'b1;
                cu_bus.ld_pc        = 1'b1;
            end
            S_F1: begin
                cu_bus.ld_ir = 1'b1;
                cu_bus.ld_pc = 1'b1;
            end
            S_DEC: begin
                cu_bus.rb_sel  = 1'b1;
                cu_bus.ld_rdir = 1'b1;
            end
            S_LD0: cu_bus.mux_1_pc = 1'b1;
            S_LD1: begin
                cu_bus.mux_1_pc = 1'b1;
                cu_bus.ld_reg   = 1'b1;
                cu_bus.ld_flags = 1'b1;
            end
            S_ST: begin
                cu_bus.mux_1_pc = 1'b1;
                cu_bus.mem_w    = 1'b1;
            end
            S_ALU: begin
                cu_bus.ld_reg   = 1'b1;
                cu_bus.reg_src  = 1'b1;
                cu_bus.ld_flags = 1'b1;
            end
            S_BR0: cu_bus.mux_1_pc = 1'b1;
            S_BR1: begin
                cu_bus.mux_1_pc = 1'b1;
                cu_bus.ld_ir    = 1'b1;
                cu_bus.ld_pc    = 1'b1;
            end
            default: ;
        endcase
    end

    assign cu_bus.state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through the
// sequencer and compares state code plus every strobe against hand tables.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk    (clk),
        .rst    (rst),
        .cu_bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] RST = 4'd0, F0 = 4'd1, F1 = 4'd2, DEC = 4'd3,
                           LD0 = 4'd4, LD1 = 4'd5, ST = 4'd6, ALU = 4'd7,
                           BR0 = 4'd8, BR1 = 4'd9;

    // Strobe vector order: ld_ir ld_pc reset_pc_sel mux_1_pc ld_rdir mem_w ld_reg reg_src rb_sel ld_flags
    function automatic logic [9:0] outv();
        return {bus.ld_ir, bus.ld_pc, bus.reset_pc_sel, bus.mux_1_pc, bus.ld_rdir,
                bus.mem_w, bus.ld_reg, bus.reg_src, bus.rb_sel, bus.ld_flags};
    endfunction

    function automatic logic [9:0] exp_out(input logic [3:0] s);
        case (s)
            RST:     return 10'b0110000000;
            F0:      return 10'b0000000000;
            F1:      return 10'b1100000000;
            DEC:     return 10'b0000100010;
            LD0:     return 10'b0001000000;
            LD1:     return 10'b0001001001;
            ST:      return 10'b0001010000;
            ALU:     return 10'b0000001101;
            BR0:     return 10'b0001000000;
            BR1:     return 10'b1101000000;
            default: return 10'b0000000000;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] seq [3] = '{F0, F1, DEC};
        bus.ir = 16'h0000; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== RST || outv() !== exp_out(RST)) begin
            n_err++;
            $display("FAIL reset_async: state=%0d outs=%b, required state=0 outs=%b", bus.state, outv(), exp_out(RST));
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.state !== RST || outv() !== exp_out(RST)) begin
            n_err++;
            $display("FAIL reset_hold: state=%0d outs=%b, required state=0 outs=%b", bus.state, outv(), exp_out(RST));
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== seq[i] || outv() !== exp_out(seq[i])) begin
                n_err++;
                $display("FAIL reset_release[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), seq[i], exp_out(seq[i]));
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] seq [6] = '{F0, F1, DEC, LD0, LD1, F0};
        bus.ir = 16'h0A05; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== seq[i] || outv() !== exp_out(seq[i])) begin
                n_err++;
                $display("FAIL load[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), seq[i], exp_out(seq[i]));
            end
        end
    endtask

    task automatic test_store();
        logic [3:0] seq [5] = '{F0, F1, DEC, ST, F0};
        bus.ir = 16'h4A10; bus.flag_z = 1'b1; bus.flag_n = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== seq[i] || outv() !== exp_out(seq[i])) begin
                n_err++;
                $display("FAIL store[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), seq[i], exp_out(seq[i]));
            end
        end
    endtask

    task automatic test_alu();
        logic [3:0] seq [5] = '{F0, F1, DEC, ALU, F0};
        bus.ir = 16'hC8A4; bus.flag_z = 1'b0; bus.flag_n = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== seq[i] || outv() !== exp_out(seq[i])) begin
                n_err++;
                $display("FAIL alu[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), seq[i], exp_out(seq[i]));
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] taken [7]   = '{F0, F1, DEC, BR0, BR1, DEC, BR0};
        logic [3:0] ntaken [4]  = '{F0, F1, DEC, F0};
        // BEQ with Z=1: target prefetched, back into DEC, branches again
        bus.ir = 16'h8820; bus.flag_z = 1'b1; bus.flag_n = 1'b0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== taken[i] || outv() !== exp_out(taken[i])) begin
                n_err++;
                $display("FAIL beq_taken[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), taken[i], exp_out(taken[i]));
            end
        end
        bus.flag_z = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== ntaken[i] || outv() !== exp_out(ntaken[i])) begin
                n_err++;
                $display("FAIL beq_not_taken[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), ntaken[i], exp_out(ntaken[i]));
            end
        end
        bus.ir = 16'hA020; bus.flag_z = 1'b1; bus.flag_n = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== ntaken[i] || outv() !== exp_out(ntaken[i])) begin
                n_err++;
                $display("FAIL branch_never[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), ntaken[i], exp_out(ntaken[i]));
            end
        end
    endtask

    task automatic test_cond_sweep();
        // taken mask per condition, bit index = {Z,N}
        logic [3:0] mask [8] = '{4'b1111, 4'b1100, 4'b1010, 4'b1110,
                                 4'b0000, 4'b0011, 4'b0101, 4'b0001};
        logic [3:0] exp_s;
        logic [1:0] zn;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 4; f++) begin
                zn = 2'(f);
                bus.ir = {2'b10, 3'(c), 11'h055};
                bus.flag_z = zn[1];
                bus.flag_n = zn[0];
                apply_reset();
                repeat (4) @(posedge clk);
                @(negedge clk);
                exp_s = mask[c][f] ? BR0 : F0;
                n_cmp++;
                if (bus.state !== exp_s) begin
                    n_err++;
                    $display("FAIL cond_sweep c=%0d z=%0d n=%0d: state=%0d, required %0d", c, zn[1], zn[0], bus.state, exp_s);
                end
            end
        end
    endtask

    task automatic test_reset_mid_st();
        logic [3:0] seq [3] = '{F0, F1, DEC};
        bus.ir = 16'h4A10; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
        apply_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.state !== ST || bus.mem_w !== 1'b1) begin
            n_err++;
            $display("FAIL mid_st_entry: state=%0d mem_w=%b, required state=6 mem_w=1", bus.state, bus.mem_w);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== RST || outv() !== exp_out(RST)) begin
            n_err++;
            $display("FAIL mid_st_abort: state=%0d outs=%b, required state=0 outs=%b", bus.state, outv(), exp_out(RST));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (bus.state !== seq[i] || outv() !== exp_out(seq[i])) begin
                n_err++;
                $display("FAIL mid_st_resume[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outv(), seq[i], exp_out(seq[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_branch();
        test_alu();
        test_cond_sweep();
        test_reset_mid_st();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
